// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, FSM state and flag types for seq_alu_core
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - shift-add multiplier, one multiplier bit per cycle
module seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            done_d   = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (cnt_q != '0);
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/seq_alu_core.sv
// rtl/seq_alu_core.sv - handshaked sequential ALU with accumulator; ALU_MUL_EN adds multi-cycle MUL
module seq_alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             err
);
    localparam int SHAMT_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
    alu_flags_t       flags_q, flags_d;
    logic [WIDTH-1:0] a_sel;

    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] shl_w, shr_w;
    logic [SHAMT_W-1:0] shamt;
    logic               shamt_ok;
    logic [WIDTH-1:0]   exec_res;
    alu_flags_t         exec_flags;

    assign a_sel = use_acc ? acc_q : a;

`ifdef ALU_MUL_EN
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    // Operands go straight from the ports so the multiply starts on the accept edge.
    assign mul_start = (state_q == ST_IDLE) && in_valid && (alu_op_e'(op) == OP_MUL);

    seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a_sel),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    always_comb begin
        sum        = {1'b0, a_q} + {1'b0, b_q};
        diff       = {1'b0, a_q} - {1'b0, b_q};
        shamt      = b_q[SHAMT_W-1:0];
        shamt_ok   = ({1'b0, b_q} < (WIDTH+1)'(WIDTH));
        shl_w      = {{WIDTH{1'b0}}, a_q} << shamt;
        shr_w      = {a_q, {WIDTH{1'b0}}} >> shamt;
        exec_res   = '0;
        exec_flags = '0;
        case (op_q)
            OP_ADD: begin
                exec_res         = sum[WIDTH-1:0];
                exec_flags.carry = sum[WIDTH];
                exec_flags.ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                exec_res         = diff[WIDTH-1:0];
                exec_flags.carry = diff[WIDTH];
                exec_flags.ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_XOR: exec_res = a_q ^ b_q;
            // Bit WIDTH / WIDTH-1 of the widened shift is the last bit pushed out.
            OP_SHL: if (shamt_ok) begin
                exec_res         = shl_w[WIDTH-1:0];
                exec_flags.carry = (shamt != '0) && shl_w[WIDTH];
            end
            OP_SHR: if (shamt_ok) begin
                exec_res         = shr_w[2*WIDTH-1:WIDTH];
                exec_flags.carry = (shamt != '0) && shr_w[WIDTH-1];
            end
            default: exec_flags.err = 1'b1;
        endcase
        exec_flags.zero = (exec_res == '0);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result_d  = result_q;
        flags_d   = flags_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d = alu_op_e'(op);
                    a_d  = a_sel;
                    b_d  = b;
`ifdef ALU_MUL_EN
                    state_d = (alu_op_e'(op) == OP_MUL) ? ST_MUL : ST_EXEC;
`else
                    state_d = ST_EXEC;
`endif
                end
            end
            ST_EXEC: begin
                result_d = exec_res;
                flags_d  = exec_flags;
                state_d  = ST_DONE;
            end
`ifdef ALU_MUL_EN
            ST_MUL: if (mul_done && !mul_busy) begin
                result_d      = mul_prod[WIDTH-1:0];
                flags_d.carry = 1'b0;
                flags_d.zero  = (mul_prod[WIDTH-1:0] == '0);
                flags_d.ovf   = (mul_prod[2*WIDTH-1:WIDTH] != '0);
                flags_d.err   = 1'b0;
                state_d       = ST_DONE;
            end
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = result_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign carry  = flags_q.carry;
    assign zero   = flags_q.zero;
    assign ovf    = flags_q.ovf;
    assign err    = flags_q.err;

endmodule

// File: tb/tb_seq_alu_core.sv
// tb/tb_seq_alu_core.sv - scoreboard testbench for seq_alu_core, WIDTH=4, ALU_MUL_EN aware
module tb_seq_alu_core;
    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, use_acc, out_valid, out_ready;
    logic         carry, zero, ovf, err;
    logic [2:0]   op;
    logic [W-1:0] a, b, result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int model_acc = 0;

    typedef struct {
        int res;
        bit carry;
        bit zero;
        bit ovf;
        bit err;
        bit chk_carry;
        int lat;
        int stamp;
    } exp_t;

    exp_t sb[$];

    seq_alu_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int to_signed(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        int s, p, ss;
        e = '{default: 0};
        e.chk_carry = 1'b1;
        e.lat = 2;
        case (o)
            0: begin
                s = x + y;
                e.res = s & MASK;
                e.carry = ((s >> W) & 1) != 0;
                ss = to_signed(x) + to_signed(y);
                e.ovf = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
            end
            1: begin
                s = x - y;
                e.res = s & MASK;
                e.carry = (x < y);
                ss = to_signed(x) - to_signed(y);
                e.ovf = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
            end
            2: e.res = x & y;
            3: e.res = x | y;
            4: e.res = x ^ y;
            5: if (y < W) begin
                e.res = (x << y) & MASK;
                e.carry = (y != 0) && (((x >> (W - y)) & 1) != 0);
            end else begin
                e.res = 0;
                e.chk_carry = 1'b0;
            end
            6: if (y < W) begin
                e.res = x >> y;
                e.carry = (y != 0) && (((x >> (y - 1)) & 1) != 0);
            end else begin
                e.res = 0;
                e.chk_carry = 1'b0;
            end
            default: begin
`ifdef ALU_MUL_EN
                p = x * y;
                e.res = p & MASK;
                e.ovf = (p >> W) != 0;
                e.lat = W + 2;
`else
                p = 0;
                e.res = p;
                e.err = 1'b1;
`endif
            end
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic send(input int o, input int x, input int y, input bit acc_sel, output int waited);
        exp_t e;
        int opa;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
            return;
        end
        opa = acc_sel ? model_acc : x;
        e = model(o, opa, y);
        e.stamp = cyc;
        sb.push_back(e);
        model_acc = e.res;
        op = 3'(o);
        a = W'(x);
        b = W'(y);
        use_acc = acc_sel;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        use_acc = 1'b0;
    endtask

    task automatic receive(input bit chk_lat);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL recv_out_valid: out_valid=%0b queued=%0d required 1 and >0", out_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        if (chk_lat) begin
            n_checks++;
            if ((cyc - e.stamp) !== e.lat) begin
                n_fail++;
                $display("FAIL latency: got %0d required %0d", cyc - e.stamp, e.lat);
            end
        end
        n_checks++;
        if (result !== W'(e.res)) begin
            n_fail++;
            $display("FAIL result: got %0d required %0d", result, e.res);
        end
        if (e.chk_carry) begin
            n_checks++;
            if (carry !== e.carry) begin
                n_fail++;
                $display("FAIL carry: got %0b required %0b", carry, e.carry);
            end
        end
        n_checks++;
        if (zero !== e.zero) begin
            n_fail++;
            $display("FAIL zero: got %0b required %0b", zero, e.zero);
        end
        n_checks++;
        if (ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL ovf: got %0b required %0b", ovf, e.ovf);
        end
        n_checks++;
        if (err !== e.err) begin
            n_fail++;
            $display("FAIL err: got %0b required %0b", err, e.err);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_done: got %0b required 0", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        use_acc = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_acc = 0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        n_checks++;
        if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %0d required 0", result); end
        n_checks++;
        if ({carry, zero, ovf, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %4b required 0000", {carry, zero, ovf, err});
        end
    endtask

    task automatic test_add();
        int w;
        send(0, 9, 8, 1'b0, w);
        receive(1'b1);
        send(0, 3, 4, 1'b0, w);
        receive(1'b1);
    endtask

    task automatic test_sub_acc();
        int w;
        send(1, 3, 5, 1'b0, w);
        receive(1'b1);
        send(1, 7, 14, 1'b1, w);
        receive(1'b1);
    endtask

    task automatic test_shift();
        int w;
        int sh_op[4] = '{5, 6, 6, 5};
        int sh_b[4]  = '{1, 4, 2, 0};
        for (int i = 0; i < 4; i++) begin
            send(sh_op[i], 11, sh_b[i], 1'b0, w);
            receive(1'b1);
        end
    endtask

    task automatic test_logic();
        int w;
        int l_op[4] = '{2, 3, 4, 4};
        int l_a[4]  = '{12, 12, 12, 5};
        int l_b[4]  = '{10, 10, 12, 10};
        for (int i = 0; i < 4; i++) begin
            send(l_op[i], l_a[i], l_b[i], 1'b0, w);
            receive(1'b1);
        end
    endtask

    task automatic test_mul();
        int w;
        send(7, 7, 3, 1'b0, w);
        receive(1'b1);
        send(7, 3, 5, 1'b0, w);
        receive(1'b1);
    endtask

    task automatic test_hold();
        int w;
        int waited = 0;
        out_ready = 1'b0;
        send(0, 5, 6, 1'b0, w);
        @(negedge clk);
        while (!out_valid && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                op = 3'd0;
                a = 4'd1;
                b = 4'd1;
                in_valid = 1'b1;
            end
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_handshake: out_valid=%0b in_ready=%0b required 1/0", out_valid, in_ready);
            end
            n_checks++;
            if (result !== W'(sb[0].res) || zero !== sb[0].zero || ovf !== sb[0].ovf || carry !== sb[0].carry) begin
                n_fail++;
                $display("FAIL hold_stable: result=%0d c/z/o=%0b%0b%0b required %0d %0b%0b%0b",
                         result, carry, zero, ovf, sb[0].res, sb[0].carry, sb[0].zero, sb[0].ovf);
            end
            if (i < 4) @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        void'(sb.pop_front());
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_in_ready: got %0b required 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_ignored_cmd: out_valid=%0b required 0", out_valid); end
            @(negedge clk);
        end
        send(0, 0, 0, 1'b1, w);
        receive(1'b1);
    endtask

    task automatic test_reset_mid_mul();
        int w;
        bit stray = 1'b0;
        send(7, 7, 3, 1'b0, w);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        n_checks++;
        if (result !== '0) begin n_fail++; $display("FAIL reset_mid_result: got %0d required 0", result); end
        reset = 1'b0;
        sb.delete();
        model_acc = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray) begin n_fail++; $display("FAIL reset_mid_stale: out_valid seen=1 required 0"); end
        send(0, 9, 0, 1'b1, w);
        receive(1'b1);
    endtask

    task automatic test_back_to_back();
        int w;
        int bb_op[6]  = '{0, 4, 1, 3, 6, 2};
        int bb_a[6]   = '{15, 6, 2, 12, 9, 7};
        int bb_b[6]   = '{1, 3, 9, 5, 1, 10};
        bit bb_acc[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(bb_op[i], bb_a[i], bb_b[i], bb_acc[i], w);
            if (i > 0) begin
                n_checks++;
                if (w !== 0) begin n_fail++; $display("FAIL b2b_accept_gap: waited %0d required 0", w); end
            end
            receive(1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_acc();
        test_shift();
        test_logic();
        test_mul();
        test_hold();
        test_reset_mid_mul();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
